// File: rtl/ps2_scancode_receiver.sv
// PS/2 keyboard receiver: synchronises and de-glitches the raw lines, captures 11-bit frames,
// and decodes E0/F0/E1 prefixes into key events. Define PS2_PARITY_CHECK_EN to enforce odd parity.
module ps2_scancode_receiver #(
  parameter int unsigned FILTER_LEN     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] key_code,
  output logic       key_pressed,
  output logic       key_extended,
  output logic       key_strobe,
  output logic       frame_error
);

  localparam int unsigned FiltW = $clog2(FILTER_LEN + 1);
  localparam int unsigned ToW   = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [FiltW-1:0] FiltMax = FiltW'(FILTER_LEN - 1);
  localparam logic [ToW-1:0]   ToMax   = ToW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StData, StParity, StStop} state_e;

  state_e           state_q, state_d;
  logic [1:0]       clk_sync_q, data_sync_q;
  logic             filt_q, filt_d, filt_prev_q;
  logic [FiltW-1:0] filt_cnt_q, filt_cnt_d;
  logic [ToW-1:0]   to_cnt_q;
  logic [2:0]       bit_cnt_q;
  logic [7:0]       shift_q;
  logic             bit_in, fall_edge, timeout, parity_ok;
  logic             start_err, stop_err, byte_valid, frame_err;
  logic             ext_q, brk_q;
  logic [2:0]       disc_q;
  logic [7:0]       key_code_q;
  logic             key_pressed_q, key_extended_q, key_strobe_q, frame_error_q;

  // Both synchronisers idle high so reset never looks like a falling edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      clk_sync_q  <= 2'b11;
      data_sync_q <= 2'b11;
    end else begin
      clk_sync_q  <= {clk_sync_q[0], ps2_clk};
      data_sync_q <= {data_sync_q[0], ps2_data};
    end
  end

  assign bit_in = data_sync_q[1];

  always_comb begin
    filt_d     = filt_q;
    filt_cnt_d = '0;
    if (clk_sync_q[1] != filt_q) begin
      if (filt_cnt_q == FiltMax) begin
        filt_d = clk_sync_q[1];
      end else begin
        filt_cnt_d = filt_cnt_q + FiltW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      filt_q      <= 1'b1;
      filt_prev_q <= 1'b1;
      filt_cnt_q  <= '0;
    end else begin
      filt_q      <= filt_d;
      filt_prev_q <= filt_q;
      filt_cnt_q  <= filt_cnt_d;
    end
  end

  assign fall_edge = filt_prev_q & ~filt_q;
  // An edge in the expiry cycle wins over the timeout.
  assign timeout   = (state_q != StIdle) && !fall_edge && (to_cnt_q == ToMax);

  // Frame state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Frame next-state logic
  always_comb begin
    state_d = state_q;
    if (timeout) begin
      state_d = StIdle;
    end else if (fall_edge) begin
      unique case (state_q)
        StIdle:   if (!bit_in) state_d = StData;
        StData:   if (bit_cnt_q == 3'd7) state_d = StParity;
        StParity: state_d = StStop;
        StStop:   state_d = StIdle;
        default:  state_d = StIdle;
      endcase
    end
  end

  // Frame outputs
  always_comb begin
    start_err  = 1'b0;
    stop_err   = 1'b0;
    byte_valid = 1'b0;
    if (fall_edge) begin
      unique case (state_q)
        StIdle: start_err = bit_in;
        StStop: begin
          byte_valid = bit_in & parity_ok;
          stop_err   = ~(bit_in & parity_ok);
        end
        default: ;
      endcase
    end
  end

  assign frame_err = start_err | stop_err | timeout;

`ifdef PS2_PARITY_CHECK_EN
  logic parity_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      parity_q <= 1'b0;
    end else if (fall_edge && state_q == StParity) begin
      parity_q <= bit_in;
    end
  end

  assign parity_ok = ^{shift_q, parity_q};
`else
  assign parity_ok = 1'b1;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      to_cnt_q  <= '0;
      bit_cnt_q <= '0;
      shift_q   <= '0;
    end else begin
      if (state_q == StIdle || fall_edge) begin
        to_cnt_q <= '0;
      end else begin
        to_cnt_q <= to_cnt_q + ToW'(1);
      end
      if (fall_edge) begin
        if (state_q == StIdle) begin
          bit_cnt_q <= '0;
        end else if (state_q == StData) begin
          shift_q   <= {bit_in, shift_q[7:1]};
          bit_cnt_q <= bit_cnt_q + 3'd1;
        end
      end
    end
  end

  // Prefix decode and event outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ext_q          <= 1'b0;
      brk_q          <= 1'b0;
      disc_q         <= '0;
      key_code_q     <= '0;
      key_pressed_q  <= 1'b0;
      key_extended_q <= 1'b0;
      key_strobe_q   <= 1'b0;
      frame_error_q  <= 1'b0;
    end else begin
      frame_error_q <= frame_err;
      if (frame_err) begin
        ext_q  <= 1'b0;
        brk_q  <= 1'b0;
        disc_q <= '0;
      end else if (byte_valid) begin
        if (disc_q != 3'd0) begin
          disc_q <= disc_q - 3'd1;
        end else begin
          case (shift_q)
            8'hE0: ext_q <= 1'b1;
            8'hF0: brk_q <= 1'b1;
            8'hE1: disc_q <= 3'd7;
            8'hAA, 8'hFA, 8'hFE, 8'hEE, 8'h00, 8'hFF: begin
            end
            default: begin
              key_code_q     <= shift_q;
              key_pressed_q  <= ~brk_q;
              key_extended_q <= ext_q;
              key_strobe_q   <= ~key_strobe_q;
              ext_q          <= 1'b0;
              brk_q          <= 1'b0;
            end
          endcase
        end
      end
    end
  end

  assign key_code     = key_code_q;
  assign key_pressed  = key_pressed_q;
  assign key_extended = key_extended_q;
  assign key_strobe   = key_strobe_q;
  assign frame_error  = frame_error_q;

endmodule

// File: tb/tb_ps2_scancode_receiver.sv
// Randomised bench for ps2_scancode_receiver against a byte-level prefix model.
module tb_ps2_scancode_receiver;

  localparam int unsigned FilterLen     = 8;
  localparam int unsigned TimeoutCycles = 1000;
  localparam int unsigned Half          = 20;
`ifdef PS2_PARITY_CHECK_EN
  localparam bit ParEn = 1'b1;
`else
  localparam bit ParEn = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic [7:0] key_code;
  logic       key_pressed, key_extended, key_strobe, frame_error;

  ps2_scancode_receiver #(
    .FILTER_LEN     (FilterLen),
    .TIMEOUT_CYCLES (TimeoutCycles)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .ps2_clk      (ps2_clk),
    .ps2_data     (ps2_data),
    .key_code     (key_code),
    .key_pressed  (key_pressed),
    .key_extended (key_extended),
    .key_strobe   (key_strobe),
    .frame_error  (frame_error)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] expd);
    n_checks++;
    if (obs !== expd) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, expd);
    end
  endtask

  // Reference model: prefix rules applied to whole accepted bytes.
  logic [9:0] exp_q[$];
  bit         m_ext, m_brk;
  int         m_disc;
  int         exp_evts = 0;
  int         exp_errs = 0;
  logic [7:0] drops[6] = '{8'hAA, 8'hFA, 8'hFE, 8'hEE, 8'h00, 8'hFF};

  task automatic model_clear();
    m_ext  = 1'b0;
    m_brk  = 1'b0;
    m_disc = 0;
  endtask

  task automatic model_byte(input logic [7:0] b);
    if (m_disc > 0) m_disc--;
    else if (b == 8'hE0) m_ext = 1'b1;
    else if (b == 8'hF0) m_brk = 1'b1;
    else if (b == 8'hE1) m_disc = 7;
    else if (!(b inside {8'hAA, 8'hFA, 8'hFE, 8'hEE, 8'h00, 8'hFF})) begin
      exp_q.push_back({b, ~m_brk, m_ext});
      exp_evts++;
      m_ext = 1'b0;
      m_brk = 1'b0;
    end
  endtask

  task automatic model_error();
    model_clear();
    exp_errs++;
  endtask

  // Output monitor, sampled on the falling clk edge.
  int   toggles = 0;
  int   err_seen = 0;
  logic strobe_prev = 1'b0;
  logic err_prev = 1'b0;

  always @(negedge clk) begin
    if (reset) begin
      strobe_prev = key_strobe;
      err_prev    = 1'b0;
    end else begin
      if (frame_error) begin
        err_seen++;
        check_eq("err_width", {31'b0, err_prev}, 32'd0);
      end
      if (key_strobe !== strobe_prev) begin
        toggles++;
        check_eq("strobe_vs_err", {31'b0, frame_error}, 32'd0);
        if (exp_q.size() == 0) begin
          check_eq("unexpected_event", {22'b0, key_code, key_pressed, key_extended}, 32'hFFFF);
        end else begin
          check_eq("event", {22'b0, key_code, key_pressed, key_extended},
                   {22'b0, exp_q.pop_front()});
        end
      end
      strobe_prev = key_strobe;
      err_prev    = frame_error;
    end
  end

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
  endtask

  task automatic send_bit(input logic b);
    ps2_data = b;
    wait_clk(Half);
    ps2_clk = 1'b0;
    wait_clk(Half);
    ps2_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input bit pbad, input bit sbad);
    if (sbad || (pbad && ParEn)) model_error();
    else model_byte(b);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit((~^b) ^ pbad);
    send_bit(~sbad);
    ps2_data = 1'b1;
    wait_clk(Half);
  endtask

  task automatic glitch();
    ps2_clk = 1'b0;
    wait_clk(3);
    ps2_clk = 1'b1;
    wait_clk(Half);
  endtask

  task automatic settle(input string tag);
    wait_clk(2 * Half);
    check_eq({tag, ":toggles"}, toggles, exp_evts);
    check_eq({tag, ":errors"}, err_seen, exp_errs);
    check_eq({tag, ":queue"}, exp_q.size(), 0);
  endtask

  task automatic check_zero_outputs(input string tag);
    check_eq({tag, ":code"}, {24'b0, key_code}, 32'd0);
    check_eq({tag, ":pressed"}, {31'b0, key_pressed}, 32'd0);
    check_eq({tag, ":ext"}, {31'b0, key_extended}, 32'd0);
    check_eq({tag, ":strobe"}, {31'b0, key_strobe}, 32'd0);
    check_eq({tag, ":ferr"}, {31'b0, frame_error}, 32'd0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] b;
    model_clear();
    wait_clk(4);
    @(negedge clk);
    check_zero_outputs("reset");
    reset = 1'b0;
    wait_clk(20);

    send_frame(8'h1C, 1'b0, 1'b0);
    settle("make_1c");
    send_frame(8'hF0, 1'b0, 1'b0);
    send_frame(8'h1C, 1'b0, 1'b0);
    settle("break_1c");
    send_frame(8'hE0, 1'b0, 1'b0);
    send_frame(8'h75, 1'b0, 1'b0);
    settle("ext_75");
    send_frame(8'hE0, 1'b0, 1'b0);
    send_frame(8'hF0, 1'b0, 1'b0);
    send_frame(8'h75, 1'b0, 1'b0);
    settle("ext_brk_75");

    send_frame(8'hE0, 1'b0, 1'b0);
    send_frame(8'h1C, 1'b1, 1'b0);
    send_frame(8'h1C, 1'b0, 1'b0);
    settle("bad_parity");
    send_frame(8'h5A, 1'b0, 1'b1);
    settle("bad_stop");

    // Bad start bit: one falling edge with data high.
    ps2_data = 1'b1;
    wait_clk(Half);
    ps2_clk = 1'b0;
    wait_clk(Half);
    ps2_clk = 1'b1;
    wait_clk(Half);
    model_error();
    settle("bad_start");

    send_frame(8'hF0, 1'b0, 1'b0);
    send_bit(1'b0);
    for (int i = 0; i < 5; i++) send_bit(1'(i & 1));
    ps2_data = 1'b1;
    wait_clk(TimeoutCycles + 50);
    model_error();
    settle("timeout");
    send_frame(8'h1C, 1'b0, 1'b0);
    settle("after_timeout");

    glitch();
    glitch();
    settle("glitch");
    send_frame(8'hE1, 1'b0, 1'b0);
    for (int i = 0; i < 7; i++) send_frame(8'($urandom_range(0, 255)), 1'b0, 1'b0);
    send_frame(8'h1C, 1'b0, 1'b0);
    settle("pause_seq");

    send_frame(8'hE0, 1'b0, 1'b0);
    send_bit(1'b0);
    for (int i = 0; i < 3; i++) send_bit(1'b1);
    reset = 1'b1;
    wait_clk(3);
    @(negedge clk);
    check_zero_outputs("mid_reset");
    model_clear();
    exp_q.delete();
    reset = 1'b0;
    wait_clk(20);
    send_frame(8'hF0, 1'b0, 1'b0);
    send_frame(8'h1C, 1'b0, 1'b0);
    settle("after_reset");

    for (int n = 0; n < 60; n++) begin
      case ($urandom_range(0, 9))
        0:       b = 8'hE0;
        1:       b = 8'hF0;
        2:       b = 8'hE1;
        3:       b = drops[$urandom_range(0, 5)];
        default: b = 8'($urandom_range(0, 255));
      endcase
      if ($urandom_range(0, 7) == 0) glitch();
      send_frame(b, $urandom_range(0, 9) == 0, $urandom_range(0, 14) == 0);
    end
    settle("random");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/ps2_scancode_receiver.md
# ps2_scancode_receiver

Receives the raw PS/2 keyboard serial stream and decodes it into scan-code events: key code, make/break state, extended flag and a toggling strobe. It handles the clock/data synchronisation, glitch filtering, 11-bit frame capture and the E0/F0 prefix logic. It sits directly upstream of the key-to-PS/2 converter and drives its `key_code`, `key_pressed` and `key_strobe` inputs.

## Interface

Parameters:
- `FILTER_LEN`, 8 — clk cycles a synchronised `ps2_clk` level must hold before the filtered level changes.
- `TIMEOUT_CYCLES`, 50000 — idle clk cycles mid-frame before the frame is abandoned (2 ms at 25 MHz).

Ports:
- `clk` input 1 — system clock. This is the block's only clock.
- `reset` input 1 — asynchronous, active-high reset.
- `ps2_clk` input 1 — raw PS/2 clock line, asynchronous to `clk`.
- `ps2_data` input 1 — raw PS/2 data line, asynchronous to `clk`.
- `key_code` output 8 — scan code of the last event, with prefixes stripped.
- `key_pressed` output 1 — 1 = make, 0 = break.
- `key_extended` output 1 — 1 if the event was preceded by E0.
- `key_strobe` output 1 — toggles once per decoded event.
- `frame_error` output 1 — one-cycle pulse on a parity, start, stop or timeout error.

## Operation

Input conditioning:
- `ps2_clk` and `ps2_data` each pass through a 2-FF synchroniser.
- The synchronised clock passes through a glitch filter.
  - A counter runs while the input differs from the filtered level.
  - The counter resets when the input matches the filtered level.
  - The filtered level flips when the counter reaches `FILTER_LEN`.
- A falling edge of the filtered clock samples the synchronised `ps2_data`.

Frame state machine:
- States: IDLE, DATA, PARITY, STOP.
- IDLE: on a falling edge with data=0 (start bit), go to DATA with the bit count cleared. A start bit of 1 raises `frame_error` and stays in IDLE.
- DATA: 8 bits arrive LSB first and shift into the byte register. After the 8th bit, go to PARITY.
- PARITY: capture the parity bit, then go to STOP.
- STOP: the stop bit must be 1 and the parity must be odd over the 8 data bits plus the parity bit.
  - Pass: hand the byte to the prefix logic.
  - Fail: pulse `frame_error` and drop the byte.
  - Either way, return to IDLE.
- Timeout: in any state other than IDLE, `TIMEOUT_CYCLES` without a filtered falling edge causes a return to IDLE and a `frame_error` pulse. Any partial byte is discarded.

Prefix logic (acts on accepted bytes):
- E0: set `ext_pending`.
- F0: set `brk_pending`.
- E1: begin discarding the next 7 bytes (Pause sequence). Discarded bytes have no other effect and emit no event.
- AA, FA, FE, EE, 00, FF: dropped. Pending flags are unchanged.
- Any other byte emits an event in a single cycle:
  - `key_code` = byte.
  - `key_pressed` = ~`brk_pending`.
  - `key_extended` = `ext_pending`.
  - `key_strobe` toggles.
  - Both pending flags clear.
- Any `frame_error` clears both pending flags and the E1 discard count.

Reset:
- All outputs are 0 in reset.
- The FSM goes to IDLE, the pending flags clear, and the counters clear.
- The filtered clock level and the synchroniser stages reset to 1 (bus idle).
- A reset during a frame discards that frame. No event or error is produced for it.

## Timing

- Raw pin to synchronised value: 2 clk cycles.
- Synchronised clock to filtered clock: `FILTER_LEN` clk cycles of stable level.
- Event output: `key_code`, `key_pressed`, `key_extended` and `key_strobe` all update on the same clk edge, 1 cycle after the filtered falling edge of the stop bit.
- Between events the outputs hold their values; downstream samples them when it sees the toggle.
- `frame_error` is high for exactly one cycle. It fires in the cycle after the stop-bit edge, the timeout expiry or the bad start bit.
- `key_strobe` never toggles in the same cycle that `frame_error` is high.
- A timeout and a falling edge in the same cycle: the edge wins and the timeout counter clears.
- Back-to-back frames need no idle gap beyond the stop bit.

## Configuration

- `PS2_PARITY_CHECK_EN`
  - Defined: an odd-parity failure raises `frame_error` and drops the byte.
  - Undefined: the parity bit is captured and ignored. Only start, stop and timeout errors are reported.

## Test plan

- Frame 0x1C, parity 0, stop 1 → `key_code`=1C, `key_pressed`=1, `key_extended`=0, `key_strobe` toggles exactly once.
- Bytes F0, 1C → one toggle only, with `key_code`=1C, `key_pressed`=0. E0, 75 → 75/1/ext 1. E0, F0, 75 → 75/0/ext 1.
- Parity forced wrong on 0x1C with macro defined → one `frame_error` pulse, no toggle. Same stimulus with macro undefined → event 1C/1.
- Clock stopped after 5 data bits for `TIMEOUT_CYCLES`+1 cycles → `frame_error` pulse. A following valid 0x1C frame decodes normally.
- 3-cycle low glitch on `ps2_clk` with `FILTER_LEN`=8 → no bit sampled. E1 plus 7 bytes, then 0x1C → the only event is 1C/1.
- `reset` asserted mid-frame after 4 bits → all outputs 0. A following valid F0, 1C sequence → event 1C/0 with a single toggle.
